llc_in_sched: RTL

//  Input-channel scheduler at the front of the LLC. Arbitrates three incoming channels
//  (rsp_in, req_in, dma_req_in) into one registered selection towards the LLC controller.

---
 rtl/llc_in_sched_pkg.sv | 22 ++
 rtl/llc_in_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/llc_in_sched_pkg.sv
// Shared constants and types for the LLC input-channel scheduler.
package llc_in_sched_pkg;

    localparam int unsigned LINE_ADDR_BITS = 26;
    localparam int unsigned HPROT_WIDTH    = 2;

    typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [HPROT_WIDTH-1:0]    hprot_t;

    // Channel id presented towards the LLC controller.
    typedef enum logic [1:0] {
        SEL_RSP = 2'd0,
        SEL_REQ = 2'd1,
        SEL_DMA = 2'd2
    } llc_in_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        DMA_LOCK = 1'b1
    } llc_in_sched_state_t;

endpackage

// File: rtl/llc_in_sched.sv
// LLC input-channel scheduler: arbitrates rsp_in / req_in / dma_req_in into one
// registered selection (channel id + line address). rsp_in has top priority,
// req/dma share round-robin, and a DMA burst lock keeps multi-beat DMA writes
// contiguous.
// Optional feature: define LLC_IN_SCHED_STARVE_EN to enable the req_in
// starvation guard (req beats rsp once after MAX_WAIT consecutive losses).
module llc_in_sched
    import llc_in_sched_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rsp_in_valid,
    input  logic [LINE_ADDR_BITS-1:0] rsp_in_addr,
    output logic                      rsp_in_ready,
    input  logic                      req_in_valid,
    input  logic [LINE_ADDR_BITS-1:0] req_in_addr,
    output logic                      req_in_ready,
    input  logic                      dma_in_valid,
    input  logic [LINE_ADDR_BITS-1:0] dma_in_addr,
    input  logic [HPROT_WIDTH-1:0]    dma_in_hprot,
    output logic                      dma_in_ready,
    output logic                      out_valid,
    output logic [1:0]                out_sel,
    input  logic                      out_ready,
    output logic [LINE_ADDR_BITS-1:0] out_addr,
    output logic                      dma_locked
);

    llc_in_sched_state_t state_q, state_d;
    llc_in_sel_t         rr_ptr_q, rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    llc_in_sel_t         out_sel_q, out_sel_d;
    line_addr_t          out_addr_q, out_addr_d;

    logic load;
    logic force_req;
    logic grant_rsp, grant_req, grant_dma;

    // Only bit 0 of hprot carries burst information.
    logic unused_hprot;
    assign unused_hprot = ^dma_in_hprot[HPROT_WIDTH-1:1];

`ifdef LLC_IN_SCHED_STARVE_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Starvation guard: req_in overrides rsp_in once it has lost MAX_WAIT times.
    always_comb begin
        force_req = (state_q == IDLE) && req_in_valid && (wait_cnt_q == WAIT_MAX);
    end

    // Count load cycles where a waiting req_in lost to rsp_in; saturate at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == IDLE) begin
            if (!req_in_valid || grant_req) begin
                wait_cnt_d = '0;
            end else if (grant_rsp && (wait_cnt_q != WAIT_MAX)) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_WAIT != 0);

    // Without the starvation guard rsp_in is strictly highest priority.
    always_comb begin
        force_req = 1'b0;
    end
`endif

    // Winner selection; grants are already qualified by reset and load.
    always_comb begin
        load      = !out_valid_q || out_ready;
        grant_rsp = 1'b0;
        grant_req = 1'b0;
        grant_dma = 1'b0;
        if (rst && load) begin
            if (force_req) begin
                grant_req = 1'b1;
            end else if (rsp_in_valid) begin
                grant_rsp = 1'b1;
            end else if (state_q == DMA_LOCK) begin
                grant_dma = dma_in_valid;
            end else if (req_in_valid && dma_in_valid) begin
                grant_req = (rr_ptr_q == SEL_REQ);
                grant_dma = (rr_ptr_q != SEL_REQ);
            end else begin
                grant_req = req_in_valid;
                grant_dma = dma_in_valid;
            end
        end
    end

    assign rsp_in_ready = grant_rsp;
    assign req_in_ready = grant_req;
    assign dma_in_ready = grant_dma;

    // Burst FSM next state: every granted DMA beat sets the lock to its hprot[0],
    // which covers IDLE->DMA_LOCK, DMA_LOCK->IDLE and single-beat bursts at once.
    always_comb begin
        state_d = state_q;
        if (grant_dma) begin
            state_d = dma_in_hprot[0] ? DMA_LOCK : IDLE;
        end
    end

    // Burst FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output selection and round-robin pointer next values.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_addr_d  = out_addr_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = grant_rsp || grant_req || grant_dma;
        end
        if (grant_rsp) begin
            out_sel_d  = SEL_RSP;
            out_addr_d = rsp_in_addr;
        end
        if (grant_req) begin
            out_sel_d  = SEL_REQ;
            out_addr_d = req_in_addr;
            rr_ptr_d   = SEL_DMA;
        end
        if (grant_dma) begin
            out_sel_d  = SEL_DMA;
            out_addr_d = dma_in_addr;
            rr_ptr_d   = SEL_REQ;
        end
    end

    // Output selection and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_sel_q   <= SEL_RSP;
            out_addr_q  <= '0;
            rr_ptr_q    <= SEL_REQ;
        end else begin
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_addr_q  <= out_addr_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sel    = out_sel_q;
    assign out_addr   = out_addr_q;
    assign dma_locked = (state_q == DMA_LOCK);

endmodule
